// File: rtl/demux4way_stream.sv
// demux4way_stream: 4-way stream demultiplexer.
//
// Routes a single producer's word stream to one of four output channels, chosen per word by
// in_sel. Each channel owns a one-entry holding register with its own valid/ready handshake,
// so the four consumers stall independently. Accepted words appear on the selected channel
// one cycle after acceptance. A channel that is drained and reloaded on the same edge keeps
// out_valid high, which sustains one word per cycle per channel.
//
// Optional feature (compile-time macro DEMUX4_COUNT_EN):
//   Adds port cnt with one CNT_W-bit wrapping accept counter per channel.
//
// Parameters:
//   WIDTH      data word width in bits (>= 1)
//   CNT_W      width of each per-channel accept counter (used only with DEMUX4_COUNT_EN)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    input word
//   in_sel     destination channel for in_data (0..3)
//   in_valid   producer offers in_data/in_sel this cycle
//   in_ready   block accepts the offered word this cycle (combinational)
//   out_data   channel k data at bits [k*WIDTH +: WIDTH]
//   out_valid  channel k holds a word
//   out_ready  consumer k takes the word this cycle
//   cnt        per-channel accept counters, channel k at [k*CNT_W +: CNT_W]
//              (DEMUX4_COUNT_EN only)

module demux4way_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready
`ifdef DEMUX4_COUNT_EN
    ,
    output logic [4*CNT_W-1:0] cnt
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("demux4way_stream: WIDTH and CNT_W must be >= 1");
    end

    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [3:0]       load;
    logic [WIDTH-1:0] data_q [4];

    // Readiness looks only at the selected channel: a full channel is still ready if its
    // consumer drains it on this same edge.
    always_comb begin
        in_ready = ~valid_q[in_sel] | out_ready[in_sel];
    end

    // One-hot load strobe for the channel that accepts this cycle.
    always_comb begin
        load = 4'b0000;
        if (in_valid && in_ready) begin
            load[in_sel] = 1'b1;
        end
    end

    // A load on the draining channel keeps it valid (back-to-back replacement).
    always_comb begin
        valid_d = load | (valid_q & ~out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 4'b0000;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;

    for (genvar k = 0; k < 4; k++) begin : g_chan
        // Data changes only on an accept to this channel; it is held while stalled and
        // retains its last value after a drain.
        always_ff @(posedge clk) begin
            if (reset) begin
                data_q[k] <= '0;
            end else if (load[k]) begin
                data_q[k] <= in_data;
            end
        end

        assign out_data[k*WIDTH +: WIDTH] = data_q[k];

`ifdef DEMUX4_COUNT_EN
        logic [CNT_W-1:0] cnt_q;

        // Natural wrap modulo 2^CNT_W.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (load[k]) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign cnt[k*CNT_W +: CNT_W] = cnt_q;
`endif
    end

endmodule

// File: tb/tb_demux4way_stream.sv
module tb_demux4way_stream;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 8;

    logic               clk;
    logic               reset;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
`ifdef DEMUX4_COUNT_EN
    logic [4*CNT_W-1:0] cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Expected words per channel, pushed by the stimulus, popped by the monitor on drain.
    logic [WIDTH-1:0] exp_q [4][$];

    demux4way_stream #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX4_COUNT_EN
        ,
        .cnt       (cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every drain (valid & ready, outside reset) must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("unexpected_word_ch%0d", k), 64'(out_data[k*WIDTH +: WIDTH]),
                              64'hDEAD);
                    end else begin
                        check($sformatf("drain_ch%0d", k), 64'(out_data[k*WIDTH +: WIDTH]),
                              64'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        for (int k = 0; k < 4; k++) exp_q[k].delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 4'b0000;
        step();
        step();
        reset = 1'b0;
        clear_queues();
    endtask

    // Offer one word; wait (bounded) for acceptance, then record the expected word.
    task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] s, output int waited);
        bit done = 1'b0;
        waited = 0;
        in_data = d;
        in_sel = s;
        in_valid = 1'b1;
        while (!done && waited < 20) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else waited++;
            step();
        end
        in_valid = 1'b0;
        if (done) exp_q[s].push_back(d);
        else check("send_timeout", 64'(waited), 64'd0);
    endtask

    initial begin
        int w;
        reset = 1'b1;
        in_data = '0;
        in_sel = 2'd0;
        in_valid = 1'b0;
        out_ready = 4'b0000;

        // Reset then idle.
        do_reset();
        step();
        step();
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_out_data", 64'(out_data), 64'h0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check($sformatf("idle_in_ready_sel%0d", s), 64'(in_ready), 64'h1);
        end
        step();

        // Single word to channel 2, consumer stalled.
        send(8'hA5, 2'd2, w);
        @(negedge clk);
        check("a5_out_valid", 64'(out_valid), 64'h4);
        check("a5_ch2_data", 64'(out_data[2*WIDTH +: WIDTH]), 64'hA5);
        in_sel = 2'd2;
        #1;
        check("full_ch2_in_ready", 64'(in_ready), 64'h0);
        in_sel = 2'd0;
        #1;
        check("other_ch0_in_ready", 64'(in_ready), 64'h1);
        step();
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        @(negedge clk);
        check("a5_drained_valid", 64'(out_valid), 64'h0);
        step();

        // Drain and reload channel 1 on the same edge.
        send(8'h11, 2'd1, w);
        out_ready = 4'b0010;
        send(8'h22, 2'd1, w);
        out_ready = 4'b0000;
        check("replace_wait", 64'(w), 64'd0);
        @(negedge clk);
        check("replace_valid", 64'(out_valid), 64'h2);
        check("replace_ch1_data", 64'(out_data[1*WIDTH +: WIDTH]), 64'h22);
        step();
        out_ready = 4'b0010;
        step();
        out_ready = 4'b0000;

        // Fill all four, then drain all in one cycle.
        send(8'h01, 2'd0, w);
        send(8'h02, 2'd1, w);
        send(8'h03, 2'd2, w);
        send(8'h04, 2'd3, w);
        @(negedge clk);
        check("fill_all_valid", 64'(out_valid), 64'hF);
        step();
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
        @(negedge clk);
        check("drain_all_valid", 64'(out_valid), 64'h0);
        check("drain_all_retain", 64'(out_data), 64'h04030201);
        step();

        // Reset wins over a simultaneous accept.
        send(8'h7E, 2'd3, w);
        in_data = 8'h55;
        in_sel = 2'd3;
        in_valid = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        clear_queues();
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_ch3_data", 64'(out_data[3*WIDTH +: WIDTH]), 64'h0);
        step();

`ifdef DEMUX4_COUNT_EN
        // 257 accepts at full throughput wrap an 8-bit counter to 1.
        check("cnt_after_reset", 64'(cnt), 64'h0);
        out_ready = 4'b0001;
        for (int i = 0; i < 257; i++) begin
            send(8'(i), 2'd0, w);
            if (w != 0) check("cnt_throughput_wait", 64'(w), 64'd0);
        end
        @(negedge clk);
        check("cnt_ch0_wrapped", 64'(cnt[0 +: CNT_W]), 64'h1);
        check("cnt_others_zero", 64'(cnt[4*CNT_W-1:CNT_W]), 64'h0);
        step();
        out_ready = 4'b0000;
        step();
`endif

        // Every word pushed must have been drained and compared.
        for (int k = 0; k < 4; k++) begin
            check($sformatf("queue_empty_ch%0d", k), 64'(exp_q[k].size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time bound in case the stimulus stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule
